// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code definitions: condition encodings and NZCV bit layout.
// Used by the execute-stage flag logic and the branch unit.
package arm_cond_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondHs = 4'b0010,
    CondLo = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  localparam logic [3:0] NZCV_RESET = 4'b0000;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: decides whether cond holds for a given NZCV.
// Shared between the execute stage and the branch unit.
module cond_eval
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_e'(cond))
      CondEq: cond_true = z;
      CondNe: cond_true = ~z;
      CondHs: cond_true = c;
      CondLo: cond_true = ~c;
      CondMi: cond_true = n;
      CondPl: cond_true = ~n;
      CondVs: cond_true = v;
      CondVc: cond_true = ~v;
      CondHi: cond_true = c & ~z;
      CondLs: cond_true = ~c | z;
      CondGe: cond_true = (n == v);
      CondLt: cond_true = (n != v);
      CondGt: cond_true = ~z & (n == v);
      CondLe: cond_true = z | (n != v);
      // NV behaves as always on this architecture.
      CondAl: cond_true = 1'b1;
      CondNv: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage back end: NZCV generation, architectural flag register with
// same-cycle forwarding to branch resolution, and the EX/MEM result register.
module ex_flag_stage
  import arm_cond_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in_flag,
  input  logic             overflow_in_flag,
  input  logic             valid,
  input  logic             set_flags,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  output logic [3:0]       nzcv_q,
  output logic [3:0]       nzcv_fwd,
  output logic             cond_true,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             valid_q
);

  logic             result_zero;
  logic [3:0]       new_nzcv;
  logic             take;
  logic [3:0]       nzcv_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             valid_d;

  assign result_zero = ~|result;

  always_comb begin
    new_nzcv        = NZCV_RESET;
    new_nzcv[N_BIT] = result[WIDTH-1];
    new_nzcv[Z_BIT] = result_zero;
    new_nzcv[C_BIT] = carry_in_flag;
    new_nzcv[V_BIT] = overflow_in_flag;
  end

  assign take = valid & set_flags & ~flush;

  // Forwarding ignores stall so a stalled flag setter is still visible to branches.
  assign nzcv_fwd = take ? new_nzcv : nzcv_q;

  always_comb begin
    nzcv_d = nzcv_q;
    if (take && !stall) begin
      nzcv_d = new_nzcv;
    end
  end

  // Flush wins over stall so a squashed instruction never lingers in EX/MEM.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
    if (flush) begin
      result_d = '0;
      zero_d   = 1'b0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      result_d = result;
      zero_d   = result_zero;
      valid_d  = valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv_q   <= NZCV_RESET;
      result_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      nzcv_q   <= nzcv_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  cond_eval u_cond_eval (
    .cond      (cond),
    .nzcv      (nzcv_fwd),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_ex_flag_stage.sv
// Self-checking bench for ex_flag_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the flag and EX/MEM state.
module tb_ex_flag_stage;

  logic        clk;
  logic        reset;
  logic [63:0] result;
  logic        carry_in_flag;
  logic        overflow_in_flag;
  logic        valid;
  logic        set_flags;
  logic        stall;
  logic        flush;
  logic [3:0]  cond;
  logic [3:0]  nzcv_q;
  logic [3:0]  nzcv_fwd;
  logic        cond_true;
  logic [63:0] result_q;
  logic        zero_q;
  logic        valid_q;

  int n_vec;
  int n_err;

  // Reference state.
  logic [3:0]  m_nzcv;
  logic [63:0] m_res;
  logic        m_zero;
  logic        m_vld;

  ex_flag_stage #(.WIDTH(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .result           (result),
    .carry_in_flag    (carry_in_flag),
    .overflow_in_flag (overflow_in_flag),
    .valid            (valid),
    .set_flags        (set_flags),
    .stall            (stall),
    .flush            (flush),
    .cond             (cond),
    .nzcv_q           (nzcv_q),
    .nzcv_fwd         (nzcv_fwd),
    .cond_true        (cond_true),
    .result_q         (result_q),
    .zero_q           (zero_q),
    .valid_q          (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ARM rule: odd encodings invert the even one, except the always pair.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[0] && c[3:1] != 3'b111) ? !base : base;
  endfunction

  function automatic logic [3:0] ref_fwd();
    logic [3:0] f;
    f = m_nzcv;
    if (valid && set_flags && !flush) f = {result[63], result == 64'd0, carry_in_flag, overflow_in_flag};
    return f;
  endfunction

  task automatic check_regs();
    check_val("nzcv_q", nzcv_q, m_nzcv);
    check_val("result_q", result_q, m_res);
    check_val("zero_q", zero_q, m_zero);
    check_val("valid_q", valid_q, m_vld);
  endtask

  // One instruction slot: drive at negedge, check comb path, clock, check registers.
  task automatic drive(input logic [63:0] r, input logic c, input logic v, input logic vl,
                       input logic sf, input logic st, input logic fl, input logic [3:0] cd);
    logic [3:0] f;
    @(negedge clk);
    result = r; carry_in_flag = c; overflow_in_flag = v; valid = vl;
    set_flags = sf; stall = st; flush = fl; cond = cd;
    #1;
    f = ref_fwd();
    check_val("nzcv_fwd", nzcv_fwd, f);
    check_val("cond_true", cond_true, ref_cond(cd, f));
    @(posedge clk);
    if (vl && sf && !fl && !st) m_nzcv = {r[63], r == 64'd0, c, v};
    if (fl) begin
      m_vld = 1'b0; m_res = 64'd0; m_zero = 1'b0;
    end else if (!st) begin
      m_vld = vl; m_res = r; m_zero = (r == 64'd0);
    end
    #1;
    check_regs();
  endtask

  initial begin
    logic [63:0] r;
    n_vec = 0; n_err = 0;
    m_nzcv = 4'b0000; m_res = 64'd0; m_zero = 1'b0; m_vld = 1'b0;
    reset = 1'b1;
    result = 64'd0; carry_in_flag = 1'b0; overflow_in_flag = 1'b0;
    valid = 1'b0; set_flags = 1'b0; stall = 1'b0; flush = 1'b0; cond = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_regs();
    check_val("rst_eq", cond_true, 1'b0);
    cond = 4'b0001;
    #1;
    check_val("rst_ne", cond_true, 1'b1);

    // Zero result sets Z, carry passes through.
    drive(64'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000);
    check_val("z_nzcv_q", nzcv_q, 4'b0110);
    check_val("z_zero_q", zero_q, 1'b1);
    check_val("z_valid_q", valid_q, 1'b1);
    check_val("z_hi", cond_true, 1'b0);

    // Non flag-setting instruction leaves flags alone.
    drive(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    check_val("nf_nzcv_q", nzcv_q, 4'b0110);
    check_val("nf_result_q", result_q, 64'h8000_0000_0000_0000);
    check_val("nf_zero_q", zero_q, 1'b0);

    // Stalled flag setter forwards but commits once, after the stall.
    repeat (3) begin
      drive(64'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      check_val("st_fwd", nzcv_fwd, 4'b0000);
      check_val("st_hold", nzcv_q, 4'b0110);
      check_val("st_res_hold", result_q, 64'h8000_0000_0000_0000);
    end
    drive(64'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    check_val("st_commit", nzcv_q, 4'b0000);
    check_val("st_res", result_q, 64'h1);

    // Flush overrides stall and never touches the flags.
    drive(64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    check_val("fl_valid_q", valid_q, 1'b0);
    check_val("fl_result_q", result_q, 64'd0);
    check_val("fl_nzcv_q", nzcv_q, 4'b0000);
    check_val("fl_fwd", nzcv_fwd, 4'b0000);

    // N=1, V=1 for signed conditions.
    drive(64'hF000_0000_0000_0005, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1010);
    check_val("nv_nzcv_q", nzcv_q, 4'b1001);
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1;
      check_val("cond_sweep", cond_true, ref_cond(4'(i), 4'b1001));
    end
    cond = 4'b1010; #1; check_val("ge", cond_true, 1'b1);
    cond = 4'b1011; #1; check_val("lt", cond_true, 1'b0);
    cond = 4'b1100; #1; check_val("gt", cond_true, 1'b1);
    cond = 4'b1110; #1; check_val("al", cond_true, 1'b1);
    cond = 4'b1111; #1; check_val("nv", cond_true, 1'b1);

    // Asynchronous reset mid-cycle.
    valid = 1'b0; set_flags = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_nzcv_q", nzcv_q, 4'b0000);
    check_val("arst_valid_q", valid_q, 1'b0);
    check_val("arst_result_q", result_q, 64'd0);
    m_nzcv = 4'b0000; m_res = 64'd0; m_zero = 1'b0; m_vld = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       r = 64'd0;
        1:       r = {1'b1, 31'($urandom), 32'($urandom)};
        default: r = {32'($urandom), 32'($urandom)};
      endcase
      drive(r, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-stage back end of the pipelined 64-bit ARM datapath. Takes the selected ALU result (add/sub, and/or, bitwise XOR) plus adder carry/overflow, and generates NZCV. It holds the architectural flag register and evaluates B.cond conditions with same-cycle flag forwarding. It also registers the result into the EX/MEM boundary under stall/flush control.

## Interface
- WIDTH, 64: datapath width in bits.
- clk  in  1: single clock; all state updates on its rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- result  in  WIDTH: ALU output selected for the instruction in EX.
- carry_in_flag  in  1: adder carry-out (C source).
- overflow_in_flag  in  1: adder signed overflow (V source).
- valid  in  1: EX holds a real instruction.
- set_flags  in  1: instruction is flag-setting (ADDS/SUBS/ANDS…).
- stall  in  1: hold EX/MEM and flag registers.
- flush  in  1: squash the EX instruction.
- cond  in  4: ARM condition field of the branch being resolved.
- nzcv_q  out  4: architectural flags {N,Z,C,V}, registered.
- nzcv_fwd  out  4: flags seen by a branch this cycle (forwarded).
- cond_true  out  1: cond satisfied by nzcv_fwd.
- result_q  out  WIDTH: EX/MEM registered result.
- zero_q  out  1: registered result == 0 (for CBZ/CBNZ in MEM).
- valid_q  out  1: EX/MEM slot holds a real instruction.

## Operation
- new_nzcv = {result[WIDTH-1], ~|result, carry_in_flag, overflow_in_flag}; combinational.
- take = valid & set_flags & ~flush.
- nzcv_fwd = take ? new_nzcv : nzcv_q (independent of stall).
- Flag register: at edge, if take & ~stall, nzcv_q <= new_nzcv; else hold.
- EX/MEM register, priority flush > stall > advance:
  - flush: valid_q<=0, result_q<=0, zero_q<=0 (even if stall high).
  - stall: hold all three.
  - advance: valid_q<=valid, result_q<=result, zero_q<=~|result.
- cond_true from nzcv_fwd: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 1.
- No arithmetic here; C and V are passed through untouched. Z is a full-width NOR.

## Timing
- Reset values: nzcv_q=0000, result_q=0, zero_q=0, valid_q=0. nzcv_fwd and cond_true follow combinationally, e.g. EQ false and NE true after reset.
- Reset asserted mid-operation: outputs clear without waiting for clk. First update occurs on the first rising edge after deassertion.
- nzcv_fwd/cond_true: zero-cycle latency from inputs (comb path).
- nzcv_q, result_q, zero_q, valid_q: one-cycle latency.
- A stalled flag-setting instruction keeps forwarding new_nzcv every cycle it sits in EX. It commits once, on the first non-stalled edge.
- valid=0 or flush=1 never changes nzcv_q.

## Structure
- Shared package arm_cond_pkg:
  - cond_e enum (EQ..NV, 4-bit).
  - NZCV bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - NZCV_RESET=4'b0000.
- One sub-module, cond_eval: combinational (cond, nzcv) -> cond_true. It is reused by the branch unit.
- Registers live in ex_flag_stage itself; zero detection is inline.

## Test plan
- Reset then release, cond=0000 → nzcv_q=0000, valid_q=0, cond_true=0; cond=0001 → cond_true=1.
- result=0, valid=1, set_flags=1, carry=1, overflow=0 → nzcv_fwd=0110 same cycle; after edge nzcv_q=0110, zero_q=1, valid_q=1; cond HI(1000) → 0.
- result=64'h8000_0000_0000_0000, set_flags=0 → nzcv_q unchanged; result_q updated, zero_q=0.
- set_flags=1, result=64'h1, stall=1 for 3 cycles → nzcv_fwd=0000 (C,V=0) throughout. nzcv_q, result_q and valid_q hold. Commit happens on the edge after stall drops.
- flush=1 with stall=1, set_flags=1, valid=1 → valid_q=0, result_q=0, nzcv_q unchanged, nzcv_fwd=nzcv_q.
- nzcv_fwd=1001 (N=1, V=1): GE → 1, LT → 0, GT → 1, AL and NV → 1. Then assert reset asynchronously mid-cycle → nzcv_q=0000 before next edge.
